writeback_unit: RTL and testbench
=================================

# writeback_unit

Final write-back stage of the CPU32 pipeline. Merges single-cycle execute results and variable-latency load results into the register file's single write port, buffering loads in a small FIFO when the port is taken. Exposes a three-port forwarding lookup so operand fetch sees writes still pending in this stage. Enforces write-after-write ordering between the two sources.

## Interface
Parameters:
- DEPTH, 4, load buffer entries; power of two, minimum 2.

Ports:
- clk_cpu  in  1  CPU clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- ex_valid  in  1  execute result present this cycle; always accepted, no backpressure.
- ex_adrs  in  5  execute destination register.
- ex_data  in  32  execute result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load accepted on this edge when ld_valid && ld_ready.
- ld_adrs  in  5  load destination register.
- ld_data  in  32  load data.
- wr_en  out  1  register file write enable (registered).
- wr_adrs  out  5  register file write address (registered).
- wr_data  out  32  register file write data (registered).
- busy  out  1  wr_en or any FIFO entry occupied (live or dead).
- lookup_adrs_a/b/c  in  5 each  operand addresses being read this cycle.
- fwd_hit_a/b/c  out  1 each  pending write to that address exists.
- fwd_data_a/b/c  out  32 each  value of youngest pending write; 0 when no hit.

## Operation
- ex_take = ex_valid && ex_adrs != 0. ld_acc = ld_valid && ld_ready. Writes to $0 are discarded: ex_adrs 0 counts as no write; ld_adrs 0 completes the handshake but is not enqueued.
- FIFO entries hold {live, adrs, data}; DEPTH entries, wrap-around read/write pointers, count 0..DEPTH.
- ld_ready = (count != DEPTH); depends on count only, never on same-cycle dequeue.
- Output register, each edge:
  - ex_take: wr_en=1, wr_adrs/wr_data = ex_adrs/ex_data; FIFO not popped.
  - else FIFO non-empty: pop head; wr_en = head.live, wr_adrs/wr_data = head fields (dead entry produces wr_en=0, still consumes the cycle).
  - else wr_en=0; wr_adrs/wr_data hold last values.
- WAW kill: on ex_take, every FIFO entry already present with adrs == ex_adrs has live cleared. A load accepted in the same cycle as an ex_take is older than it: if its adrs matches, it is enqueued dead.
- Enqueue and dequeue in the same cycle are both performed; count unchanged.
- Forwarding (combinational, per port): lookup 0 -> hit 0, data 0. Otherwise youngest live FIFO entry with matching adrs wins; else wr_en && wr_adrs match; else no hit. Same-cycle ex/ld inputs are not forwarded.

## Timing
- Reset values: wr_en 0, wr_adrs 0, wr_data 0, FIFO empty with all entries dead, pointers 0, busy 0, ld_ready 1, fwd_hit_* 0, fwd_data_* 0.
- Execute result: wr_en one cycle after ex_valid; register file commits on the following edge.
- Load, idle stage: accepted at edge N, wr_en after edge N+1 (2-cycle latency).
- Continuous ex_take starves the FIFO; loads stall via ld_ready once count = DEPTH.
- Reset asserted mid-operation discards all buffered and in-flight writes immediately; nothing is written after release until new input.
- busy and ld_ready are combinational from registered state; fwd_* are combinational from lookup_adrs and registered state.

## Test plan
- Reset: after reset release, outputs match reset values; ex_valid=1, ex_adrs=3, ex_data=0x11 -> next cycle wr_en=1, wr_adrs=3, wr_data=0x11.
- $0 discard: ex_adrs=0 and a load with ld_adrs=0 -> wr_en stays 0, ld handshake completes, busy stays 0.
- Backpressure: hold ex_valid=1 (adrs 1..) and offer 5 loads with DEPTH=4 -> 4 accepted, ld_ready=0 on the 5th. Drop ex_valid -> loads written in order, one per cycle; ld_ready returns 1 after the first pop.
- WAW kill: enqueue load r5=0xAA while ex busy, then ex r5=0xBB -> wr r5=0xBB once; dead entry pops with wr_en=0; r5 is never written 0xAA.
- Forwarding: FIFO holds r7=0x1 then r7=0x2, wr_en with r7=0x0 -> lookup_adrs_a=7 gives hit=1, data=0x2; lookup 0 gives hit 0, data 0.
- Mid-operation reset: FIFO holding 3 entries, assert reset for 1 cycle -> busy=0, wr_en=0 immediately, no writes afterward.

Source files
------------

// File: rtl/writeback_unit.sv
// CPU32 write-back stage: merges execute and load results into the single
// register file write port, with a load buffer, WAW kill and forwarding.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_adrs,
    input  logic [31:0] ex_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_adrs,
    input  logic [31:0] ld_data,
    output logic        wr_en,
    output logic [4:0]  wr_adrs,
    output logic [31:0] wr_data,
    output logic        busy,
    input  logic [4:0]  lookup_adrs_a,
    input  logic [4:0]  lookup_adrs_b,
    input  logic [4:0]  lookup_adrs_c,
    output logic        fwd_hit_a,
    output logic        fwd_hit_b,
    output logic        fwd_hit_c,
    output logic [31:0] fwd_data_a,
    output logic [31:0] fwd_data_b,
    output logic [31:0] fwd_data_c
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       adrs_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_adrs_q, wr_adrs_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic ex_take;
    logic ld_acc;
    logic ld_enq;
    logic pop;

    logic [4:0]  lk   [3];
    logic        hit  [3];
    logic [31:0] fdat [3];

    assign ld_ready = (count_q != CNT_FULL);
    assign ex_take  = ex_valid && (ex_adrs != 5'd0);
    assign ld_acc   = ld_valid && ld_ready;
    assign ld_enq   = ld_acc && (ld_adrs != 5'd0);
    assign pop      = !ex_take && (count_q != '0);

    assign busy    = wr_en_q || (count_q != '0);
    assign wr_en   = wr_en_q;
    assign wr_adrs = wr_adrs_q;
    assign wr_data = wr_data_q;

    // Next state: WAW kill, FIFO pointers/occupancy and output register select
    always_comb begin
        live_d    = live_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_adrs_d = wr_adrs_q;
        wr_data_d = wr_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ex_take && adrs_q[i] == ex_adrs) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rptr_q] = 1'b0;
            rptr_d         = rptr_q + AW'(1);
        end
        if (ld_enq) begin
            live_d[wptr_q] = !(ex_take && ld_adrs == ex_adrs);
            wptr_d         = wptr_q + AW'(1);
        end
        if (ld_enq && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!ld_enq && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (ex_take) begin
            wr_en_d   = 1'b1;
            wr_adrs_d = ex_adrs;
            wr_data_d = ex_data;
        end else if (pop) begin
            wr_en_d   = live_q[rptr_q];
            wr_adrs_d = adrs_q[rptr_q];
            wr_data_d = data_q[rptr_q];
        end
    end

    // Control state and output register
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            live_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_adrs_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            live_q    <= live_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_adrs_q <= wr_adrs_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Load buffer payload; validity is tracked by live_q/count_q
    always_ff @(posedge clk_cpu) begin
        if (ld_enq) begin
            adrs_q[wptr_q] <= ld_adrs;
            data_q[wptr_q] <= ld_data;
        end
    end

    // Forwarding: output register first, then buffer oldest-to-youngest
    always_comb begin
        logic [AW-1:0] idx;
        idx   = '0;
        lk[0] = lookup_adrs_a;
        lk[1] = lookup_adrs_b;
        lk[2] = lookup_adrs_c;
        for (int p = 0; p < 3; p++) begin
            hit[p]  = 1'b0;
            fdat[p] = 32'd0;
            if (lk[p] != 5'd0) begin
                if (wr_en_q && wr_adrs_q == lk[p]) begin
                    hit[p]  = 1'b1;
                    fdat[p] = wr_data_q;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    idx = rptr_q + AW'(k);
                    if (live_q[idx] && adrs_q[idx] == lk[p]) begin
                        hit[p]  = 1'b1;
                        fdat[p] = data_q[idx];
                    end
                end
            end
        end
    end

    assign fwd_hit_a  = hit[0];
    assign fwd_hit_b  = hit[1];
    assign fwd_hit_c  = hit[2];
    assign fwd_data_a = fdat[0];
    assign fwd_data_b = fdat[1];
    assign fwd_data_c = fdat[2];

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit against a queue-based reference
// model of pending loads and the expected register file write stream.
module tb_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_adrs;
    logic [31:0] ex_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_adrs;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [4:0]  wr_adrs;
    logic [31:0] wr_data;
    logic        busy;
    logic [4:0]  lookup_adrs_a, lookup_adrs_b, lookup_adrs_c;
    logic        fwd_hit_a, fwd_hit_b, fwd_hit_c;
    logic [31:0] fwd_data_a, fwd_data_b, fwd_data_c;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .ex_valid(ex_valid), .ex_adrs(ex_adrs), .ex_data(ex_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_adrs(ld_adrs), .ld_data(ld_data),
        .wr_en(wr_en), .wr_adrs(wr_adrs), .wr_data(wr_data),
        .busy(busy),
        .lookup_adrs_a(lookup_adrs_a), .lookup_adrs_b(lookup_adrs_b),
        .lookup_adrs_c(lookup_adrs_c),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_hit_c(fwd_hit_c),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .fwd_data_c(fwd_data_c)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    ent_t        mq[$];
    exp_t        sbq[$];
    logic        lw_en = 1'b0;
    logic [4:0]  lw_a  = '0;
    logic [31:0] lw_d  = '0;
    int          cyc   = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk_cpu) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [4:0] a);
        if (a == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].live && mq[i].a == a) return {1'b1, mq[i].d};
        end
        if (lw_en && lw_a == a) return {1'b1, lw_d};
        return 33'd0;
    endfunction

    // Monitor: every write on the port must be the next expected one
    always @(posedge clk_cpu) begin
        exp_t e;
        #1;
        if (!reset && wr_en) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_write: got adrs=%0d data=%h, required no write",
                         wr_adrs, wr_data);
            end else begin
                e = sbq.pop_front();
                chk("wr_adrs", {27'd0, wr_adrs}, {27'd0, e.a});
                chk("wr_data", wr_data, e.d);
                chk("wr_cycle", cyc, e.c);
            end
        end
    end

    task automatic cycle(input bit ev, input logic [4:0] ea,
                         input logic [31:0] ed, input bit lv,
                         input logic [4:0] la, input logic [31:0] ldd,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2);
        logic [32:0] f;
        bit rdy, take;
        ent_t e;
        @(negedge clk_cpu);
        ex_valid = ev; ex_adrs = ea; ex_data = ed;
        ld_valid = lv; ld_adrs = la; ld_data = ldd;
        lookup_adrs_a = a0; lookup_adrs_b = a1; lookup_adrs_c = a2;
        #1;
        rdy = (mq.size() != DEPTH);
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, rdy});
        chk("busy", {31'd0, busy}, {31'd0, lw_en || mq.size() != 0});
        f = model_fwd(a0);
        chk("fwd_hit_a", {31'd0, fwd_hit_a}, {31'd0, f[32]});
        chk("fwd_data_a", fwd_data_a, f[31:0]);
        f = model_fwd(a1);
        chk("fwd_hit_b", {31'd0, fwd_hit_b}, {31'd0, f[32]});
        chk("fwd_data_b", fwd_data_b, f[31:0]);
        f = model_fwd(a2);
        chk("fwd_hit_c", {31'd0, fwd_hit_c}, {31'd0, f[32]});
        chk("fwd_data_c", fwd_data_c, f[31:0]);
        take = ev && ea != 5'd0;
        if (take) begin
            foreach (mq[i]) if (mq[i].a == ea) mq[i].live = 1'b0;
            sbq.push_back('{a: ea, d: ed, c: cyc + 1});
            lw_en = 1'b1; lw_a = ea; lw_d = ed;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            lw_en = e.live;
            if (e.live) begin
                sbq.push_back('{a: e.a, d: e.d, c: cyc + 1});
                lw_a = e.a; lw_d = e.d;
            end
        end else begin
            lw_en = 1'b0;
        end
        if (lv && rdy && la != 5'd0) begin
            mq.push_back('{a: la, d: ldd, live: !(take && la == ea)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 7, 5, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_cpu);
        reset = 1'b1;
        ex_valid = 1'b0;
        ld_valid = 1'b0;
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        mq.delete();
        sbq.delete();
        lw_en = 1'b0; lw_a = '0; lw_d = '0;
        @(negedge clk_cpu);
        reset = 1'b0;
    endtask

    initial begin
        int ex_p;
        reset = 1'b1;
        ex_valid = 0; ex_adrs = 0; ex_data = 0;
        ld_valid = 0; ld_adrs = 0; ld_data = 0;
        lookup_adrs_a = 5; lookup_adrs_b = 0; lookup_adrs_c = 3;
        repeat (2) @(negedge clk_cpu);
        reset = 1'b0;
        #1;
        chk("init_wr_en", {31'd0, wr_en}, 32'd0);
        chk("init_wr_adrs", {27'd0, wr_adrs}, 32'd0);
        chk("init_wr_data", wr_data, 32'd0);
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("init_fwd_hit_a", {31'd0, fwd_hit_a}, 32'd0);
        chk("init_fwd_data_a", fwd_data_a, 32'd0);

        cycle(1, 3, 32'h11, 0, 0, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 3, 0, 1);
        idle(1);

        cycle(1, 0, 32'h55, 1, 0, 32'h66, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++)
            cycle(1, 5'(i + 1), 32'h100 + i, 1, 5'(i + 8), 32'h200 + i,
                  5'(i + 8), 8, 11);
        idle(DEPTH + 2);

        cycle(1, 1, 32'h1, 1, 5, 32'hAA, 5, 0, 0);
        cycle(1, 5, 32'hBB, 0, 0, 0, 5, 5, 1);
        idle(3);

        cycle(1, 1, 32'h10, 1, 7, 32'h0, 7, 0, 0);
        cycle(1, 2, 32'h20, 1, 7, 32'h1, 7, 0, 0);
        cycle(1, 3, 32'h30, 1, 7, 32'h2, 7, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 7, 0, 7);
        cycle(0, 0, 0, 0, 0, 0, 7, 0, 7);
        idle(3);

        cycle(1, 1, 32'hA1, 1, 9, 32'hB1, 9, 0, 0);
        cycle(1, 2, 32'hA2, 1, 10, 32'hB2, 10, 0, 0);
        cycle(1, 3, 32'hA3, 1, 11, 32'hB3, 11, 0, 0);
        do_reset();
        idle(DEPTH + 2);

        for (int blk = 0; blk < 8; blk++) begin
            ex_p = $urandom_range(0, 100);
            for (int i = 0; i < 50; i++) begin
                cycle($urandom_range(0, 99) < ex_p, 5'($urandom_range(0, 7)),
                      $urandom, $urandom_range(0, 1) == 1,
                      5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)));
            end
        end
        idle(DEPTH + 3);
        @(posedge clk_cpu);
        #2;
        chk("sb_drain", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
